// File: rtl/split_result_collector_if.sv
// Candidate handshake bundle between the split constraint blocks and the collector.
interface split_result_collector_if #(
  parameter int NUM_SPLITS = 8,
  parameter int IDX_W      = 16
);
  logic                  cand_valid;
  logic                  cand_ready;
  logic [IDX_W-1:0]      cand_idx;
  logic                  cand_last;
  logic [NUM_SPLITS-1:0] split_x;
  logic [NUM_SPLITS-1:0] split_mask;

  modport master (
    output cand_valid, cand_idx, cand_last, split_x, split_mask,
    input  cand_ready
  );

  modport slave (
    input  cand_valid, cand_idx, cand_last, split_x, split_mask,
    output cand_ready
  );
endinterface

// File: rtl/split_result_collector.sv
// Collects per-split constraint bits, evaluates the enabled-split conjunction
// in a two-stage pipe, and keeps tested/satisfied statistics for one sweep.

// A disabled split always passes, so an all-zero mask is a vacuous hit.
module split_lane_eval (
  input  logic x,
  input  logic mask,
  output logic pass
);
  assign pass = x | ~mask;
endmodule

module split_result_collector #(
  parameter int NUM_SPLITS = 8,
  parameter int IDX_W      = 16,
  parameter int CNT_W      = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  split_result_collector_if.slave   cand,
  output logic                      busy,
  output logic                      done,
  output logic [CNT_W-1:0]          tested_count,
  output logic [CNT_W-1:0]          sat_count,
  output logic                      sat_pulse,
  output logic [IDX_W-1:0]          sat_idx,
  output logic                      first_sat_valid,
  output logic [IDX_W-1:0]          first_sat_idx
);
  localparam int STAGES = 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                state_q, state_d;
  logic                  accept;
  logic                  sweep_start;
  logic [NUM_SPLITS-1:0] lane_pass;
  logic [STAGES:1]       vld_pipe;
  logic                  s1_hit;
  logic [IDX_W-1:0]      s1_idx;

  for (genvar gi = 0; gi < NUM_SPLITS; gi++) begin : g_lane
    split_lane_eval u_lane (
      .x    (cand.split_x[gi]),
      .mask (cand.split_mask[gi]),
      .pass (lane_pass[gi])
    );
  end

  assign accept      = cand.cand_valid & cand.cand_ready;
  assign sweep_start = start & ((state_q == S_IDLE) | (state_q == S_DONE));

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (accept && cand.cand_last) state_d = S_DRAIN;
      S_DRAIN: state_d = S_DONE;
      S_DONE:  if (start) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
  end

  // Ready is a pure function of state so upstream never sees a valid->ready path.
  always_comb begin
    cand.cand_ready = (state_q == S_RUN);
    busy            = (state_q == S_RUN) | (state_q == S_DRAIN);
    done            = (state_q == S_DONE);
  end

  // Stage 1: capture the conjunction and index of each accepted candidate.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      s1_hit   <= 1'b0;
      s1_idx   <= '0;
    end else begin
      vld_pipe[1] <= accept;
      if (accept) begin
        s1_hit <= &lane_pass;
        s1_idx <= cand.cand_idx;
      end
    end
  end

  // Stage 2: statistics. A pending stage never coincides with a sweep start,
  // since starts are only honoured in IDLE/DONE where nothing is in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      tested_count    <= '0;
      sat_count       <= '0;
      sat_pulse       <= 1'b0;
      sat_idx         <= '0;
      first_sat_valid <= 1'b0;
      first_sat_idx   <= '0;
    end else begin
      sat_pulse <= vld_pipe[1] & s1_hit;
      if (sweep_start) begin
        tested_count    <= '0;
        sat_count       <= '0;
        sat_idx         <= '0;
        first_sat_valid <= 1'b0;
        first_sat_idx   <= '0;
      end else if (vld_pipe[1]) begin
        if (~&tested_count) tested_count <= tested_count + CNT_W'(1);
        if (s1_hit) begin
          if (~&sat_count) sat_count <= sat_count + CNT_W'(1);
          sat_idx <= s1_idx;
          if (!first_sat_valid) begin
            first_sat_valid <= 1'b1;
            first_sat_idx   <= s1_idx;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_split_result_collector.sv
// Randomized and directed sweeps against a cycle-level reference model; a
// second instance with 4-bit counters exercises saturation.
module tb_split_result_collector;
  localparam int NS = 8;
  localparam int IW = 16;

  logic clk = 1'b0;
  logic rst, start;
  always #5 clk = ~clk;

  split_result_collector_if #(.NUM_SPLITS(NS), .IDX_W(IW)) ifc  ();
  split_result_collector_if #(.NUM_SPLITS(NS), .IDX_W(IW)) ifc4 ();

  assign ifc4.cand_valid = ifc.cand_valid;
  assign ifc4.cand_idx   = ifc.cand_idx;
  assign ifc4.cand_last  = ifc.cand_last;
  assign ifc4.split_x    = ifc.split_x;
  assign ifc4.split_mask = ifc.split_mask;

  logic          busy, done, sat_pulse, first_sat_valid;
  logic [15:0]   tested_count, sat_count;
  logic [IW-1:0] sat_idx, first_sat_idx;
  logic          busy4, done4, sat_pulse4, first_sat_valid4;
  logic [3:0]    tested_count4, sat_count4;
  logic [IW-1:0] sat_idx4, first_sat_idx4;

  split_result_collector #(.NUM_SPLITS(NS), .IDX_W(IW), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .cand(ifc.slave),
    .busy(busy), .done(done), .tested_count(tested_count), .sat_count(sat_count),
    .sat_pulse(sat_pulse), .sat_idx(sat_idx),
    .first_sat_valid(first_sat_valid), .first_sat_idx(first_sat_idx)
  );

  split_result_collector #(.NUM_SPLITS(NS), .IDX_W(IW), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .cand(ifc4.slave),
    .busy(busy4), .done(done4), .tested_count(tested_count4), .sat_count(sat_count4),
    .sat_pulse(sat_pulse4), .sat_idx(sat_idx4),
    .first_sat_valid(first_sat_valid4), .first_sat_idx(first_sat_idx4)
  );

  int vectors = 0;
  int errs    = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 run, 2 drain, 3 done; counts kept unbounded.
  int m_st, m_tested, m_sat, m_sidx, m_fidx, m_pi;
  bit m_pv, m_ph, m_pulse, m_first, m_fresh, m_acc;
  logic [7:0] x_tab[$];

  function automatic bit all_enabled_pass(logic [7:0] x, logic [7:0] m);
    for (int i = 0; i < NS; i++)
      if (m[i] && !x[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic longint clip(int v, int w);
    longint mx = (64'd1 << w) - 1;
    return (v > mx) ? mx : longint'(v);
  endfunction

  task automatic model_edge();
    bit hit;
    if (rst) begin
      m_st = 0; m_pv = 0; m_ph = 0; m_pi = 0; m_tested = 0; m_sat = 0;
      m_pulse = 0; m_first = 0; m_sidx = 0; m_fidx = 0; m_fresh = 1; m_acc = 0;
      return;
    end
    m_acc = ifc.cand_valid && (m_st == 1);
    hit   = all_enabled_pass(ifc.split_x, ifc.split_mask);
    m_pulse = m_pv && m_ph;
    if (m_pv) begin
      m_tested++;
      if (m_ph) begin
        m_sat++;
        m_sidx = m_pi;
        if (!m_first) begin m_first = 1; m_fidx = m_pi; end
      end
    end
    if (start && (m_st == 0 || m_st == 3)) begin
      m_tested = 0; m_sat = 0; m_first = 0; m_sidx = 0; m_fresh = 0; m_st = 1;
    end else if (m_st == 1 && m_acc && ifc.cand_last) m_st = 2;
    else if (m_st == 2) m_st = 3;
    m_pv = m_acc; m_ph = hit; m_pi = int'(ifc.cand_idx);
  endtask

  task automatic check_all();
    chk("cand_ready", ifc.cand_ready, m_st == 1);
    chk("busy", busy, m_st == 1 || m_st == 2);
    chk("done", done, m_st == 3);
    chk("tested_count", tested_count, clip(m_tested, 16));
    chk("sat_count", sat_count, clip(m_sat, 16));
    chk("sat_pulse", sat_pulse, m_pulse);
    chk("sat_idx", sat_idx, m_sidx);
    chk("first_sat_valid", first_sat_valid, m_first);
    if (m_first || m_fresh) chk("first_sat_idx", first_sat_idx, m_fidx);
    chk("tested_count4", tested_count4, clip(m_tested, 4));
    chk("sat_count4", sat_count4, clip(m_sat, 4));
    chk("done4", done4, m_st == 3);
  endtask

  task automatic cyc(input bit r, input bit s, input bit v, input int idx,
                     input bit last, input logic [7:0] x, input logic [7:0] m);
    rst = r; start = s;
    ifc.cand_valid = v; ifc.cand_idx = IW'(idx); ifc.cand_last = last;
    ifc.split_x = x; ifc.split_mask = m;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  // vmode: 0 every cycle, 1 alternate cycles, 2 random; xmode: 0 all ones, 1 random, 2 x_tab
  task automatic sweep(input int n, input int vmode, input int xmode, input logic [7:0] mask,
                       input bit rmask, input bit start_noise, input int base);
    int k = 0;
    int t = 0;
    bit v, s;
    logic [7:0] x, mk;
    cyc(0, 1, 0, 0, 0, 8'h00, mask);
    while (k < n && t < 1000) begin
      if (vmode == 0) v = 1'b1;
      else if (vmode == 1) v = (t % 2 == 0);
      else v = ($urandom % 100) < 60;
      mk = rmask ? (($urandom % 4 == 0) ? 8'h00 : 8'($urandom)) : mask;
      if (xmode == 0) x = 8'hFF;
      else if (xmode == 1) x = ($urandom % 2 == 1) ? (8'($urandom) | mk) : 8'($urandom);
      else x = x_tab[k];
      s = start_noise && ($urandom % 3 == 0);
      cyc(0, s, v, base + k, k == n - 1, x, mk);
      if (m_acc) k++;
      t++;
    end
    if (k < n) chk("sweep_timeout", k, n);
    cyc(0, 0, 1'($urandom), 7, 0, 8'($urandom), 8'h00);
    cyc(0, 0, 1'($urandom), 9, 0, 8'($urandom), 8'h00);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0;
    ifc.cand_valid = 0; ifc.cand_idx = '0; ifc.cand_last = 0;
    ifc.split_x = '0; ifc.split_mask = '0;
    repeat (3) cyc(1, 0, 0, 0, 0, 8'h00, 8'h00);
    cyc(0, 0, 1, 5, 0, 8'hFF, 8'hFF);

    sweep(4, 0, 0, 8'hFF, 0, 0, 0);
    x_tab = '{8'hF0, 8'h0F, 8'h1F};
    sweep(3, 0, 2, 8'h0F, 0, 0, 0);
    sweep(3, 0, 1, 8'h00, 0, 0, 40);
    sweep(5, 1, 0, 8'hFF, 0, 1, 100);
    sweep(20, 0, 0, 8'hFF, 0, 0, 200);

    // Reset mid-sweep after three accepts.
    cyc(0, 1, 0, 0, 0, 8'h00, 8'hFF);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 300 + i, 0, 8'hFF, 8'hFF);
    cyc(1, 0, 1, 303, 0, 8'hFF, 8'hFF);
    cyc(0, 0, 1, 304, 0, 8'hFF, 8'hFF);
    sweep(4, 0, 1, 8'h33, 0, 0, 400);

    for (int r = 0; r < 25; r++)
      sweep($urandom_range(1, 12), 2, 1, 8'h00, 1, 1'($urandom), int'($urandom % 60000));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule

// File: doc/split_result_collector.md
# split_result_collector

Sequential collector that sits directly downstream of the per-split constraint modules of the BDD-solver benchmark harness. Each cycle it accepts one candidate assignment index plus the single-bit `x` outputs of up to `NUM_SPLITS` split constraint blocks, and evaluates the conjunction of the enabled splits. It tracks tested and satisfying counts, captures the first satisfying index, and reports completion after the last candidate of a sweep. Its outputs feed the solver's result/statistics logic.

## Interface
- `NUM_SPLITS`, 8, number of split constraint outputs collected (1..64)
- `IDX_W`, 16, width of candidate assignment index
- `CNT_W`, 16, width of tested/satisfied counters

- `clk`  in  1  single clock, all state on rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  begin a sweep; honoured only in IDLE or DONE
- `split_mask`  in  NUM_SPLITS  1 = split participates; sampled with each accepted candidate
- `cand_valid`  in  1  candidate present
- `cand_ready`  out  1  collector can accept; reset 0
- `cand_idx`  in  IDX_W  candidate assignment index
- `cand_last`  in  1  final candidate of sweep
- `split_x`  in  NUM_SPLITS  constraint results for `cand_idx`, bit i from split_i
- `busy`  out  1  state is RUN or DRAIN; reset 0
- `done`  out  1  state is DONE; reset 0
- `tested_count`  out  CNT_W  candidates evaluated; reset 0
- `sat_count`  out  CNT_W  candidates satisfying all enabled splits; reset 0
- `sat_pulse`  out  1  one-cycle pulse per satisfying candidate; reset 0
- `sat_idx`  out  IDX_W  index of the most recent satisfying candidate; reset 0
- `first_sat_valid`  out  1  at least one hit this sweep; reset 0
- `first_sat_idx`  out  IDX_W  index of the first hit this sweep; reset 0

## Operation
- States: IDLE, RUN, DRAIN, DONE. Reset enters IDLE.
- IDLE: `cand_ready`=0. `start` clears both counters, `first_sat_valid`, and `sat_idx`, then enters RUN.
- RUN: `cand_ready`=1. An accept is `cand_valid & cand_ready`.
  - On accept, stage 1 registers `hit = &(split_x | ~split_mask)`, `cand_idx`, and a stage-valid bit.
  - When `cand_last` is set on the accept, the state moves to DRAIN.
- Stage 2, on the edge after stage-valid:
  - `tested_count` += 1.
  - If `hit`: `sat_count` += 1, `sat_pulse`=1, `sat_idx`=idx.
  - If `hit` and `first_sat_valid`=0: `first_sat_idx`=idx, `first_sat_valid`=1.
- DRAIN: `cand_ready`=0. Moves to DONE on the next edge, the same edge the last candidate's stage-2 update lands.
- DONE: `done`=1 and all results are held. `start` clears the results and re-enters RUN. `cand_valid` is ignored.
- `start` in RUN/DRAIN is ignored.
- Counters saturate at all-ones and never wrap.
- `split_mask` all zero: every candidate is a hit (vacuous conjunction).
- `rst` at any cycle, including mid-sweep, returns every output to its reset value on that edge. The in-flight stage is discarded.
- `sat_pulse` is 0 in every cycle without a stage-2 hit.

## Timing
- Throughput: one candidate per cycle in RUN. No bubbles are required.
- Candidate accepted at edge E: counters, `sat_pulse`, `sat_idx`, and first-hit fields are visible after edge E+1.
- Last candidate accepted at edge E: `cand_ready` is 0 after E. `done`=1 with final counts after E+1.
- `start` sampled at edge S: `busy`=1 and `cand_ready`=1 after S. Cleared results are visible after S.
- `cand_ready` does not depend combinationally on `cand_valid`; it is a function of state only.

## Test plan
- Reset, then a 4-candidate sweep (idx 0..3, all `split_x`=8'hFF, mask 8'hFF, last on idx 3) -> `tested_count`=4, `sat_count`=4, `first_sat_idx`=0, `done` high 1 cycle after the last accept edge.
- Mask 8'h0F, candidates with `split_x`=8'hF0, 8'h0F, 8'h1F (last) -> `sat_count`=2, `first_sat_idx`=1, `sat_pulse` high exactly 2 cycles.
- Mask 8'h00 with 3 candidates, `split_x`=0 -> `sat_count`=3 (vacuous), `tested_count`=3.
- `cand_valid` gapped (valid on alternate cycles, 5 candidates) plus `start` asserted in RUN -> `start` ignored, `tested_count`=5, no double counting.
- `CNT_W`=4, 20 hitting candidates -> both counters stop at 15.
- Sweep in progress (3 accepted), `rst` pulsed -> all outputs 0, state IDLE. A new `start` then runs a clean sweep with counts starting at 0.
